// File: rtl/press_pkg.sv
// Shared types for the button press classifier.
// Holds the state encoding and a small sizing helper.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    REPEAT,
    WAIT_REL
  } press_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced presses as short, long or held.
// While held, it emits auto-repeat pulses at a fixed interval.
module press_classifier #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic i_signal,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_event,
  output logic o_held
);
  import press_pkg::*;

  localparam int CNT_W = $clog2(max2(LONG_MS, REPEAT_MS) + 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_MS - 1);

  press_state_t     r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_long_tc, w_rep_tc;
  logic             w_short, w_long, w_rep, w_held;
  logic             r_short, r_long, r_rep, r_held;

  assign w_long_tc = tick && (r_cnt == LONG_TC);
  assign w_rep_tc  = tick && (r_cnt == REP_TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_short <= w_short;
      r_long  <= w_long;
      r_rep   <= w_rep;
      r_held  <= w_held;
    end
  end

  // Release is checked first so it beats a coincident terminal tick.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (i_signal) w_next = PRESS;
      end
      PRESS: begin
        if (!i_signal) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else if (w_long_tc) begin
          w_next    = REPEAT_EN ? REPEAT : WAIT_REL;
          w_cnt_nxt = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!i_signal) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end else if (w_rep_tc) begin
          w_cnt_nxt = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        w_cnt_nxt = '0;
        if (!i_signal) w_next = IDLE;
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_short = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    unique case (1'b1)
      (r_state == PRESS): begin
        w_short = !i_signal;
        w_long  = i_signal && w_long_tc;
      end
      (r_state == REPEAT): begin
        w_rep = i_signal && w_rep_tc;
      end
      default: ;
    endcase
    w_held = (w_next == REPEAT) || (w_next == WAIT_REL);
  end

  assign o_short  = r_short;
  assign o_long   = r_long;
  assign o_repeat = r_rep;
  assign o_event  = r_short | r_long | r_rep;
  assign o_held   = r_held;

endmodule
